vga_frame_reader: RTL and testbench

Display-side reader for the camera frame buffer. It generates 640x480@60 Hz VGA timing from a 25 MHz pixel clock and reads the 160x120 RGB332 frame from port B of the capture dual-port RAM. It upscales the frame 4x in each direction and drives registered VGA sync and colour outputs. It sits between the frame-buffer RAM, which the capture path fills through its write port, and the board's VGA connector.

---
 rtl/vga_frame_reader_pkg.sv | 38 +++
 rtl/vga_timing_gen.sv | 63 ++++++
 rtl/vga_frame_reader.sv | 120 ++++++++++++
 tb/tb_vga_frame_reader.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/vga_frame_reader_pkg.sv
// Shared definitions for the display reader and the camera capture path:
// default 640x480@60 timing, frame-buffer geometry and RGB332 field layout.
package vga_frame_reader_pkg;

   localparam int VGA_H_ACTIVE = 640;
   localparam int VGA_H_FP     = 16;
   localparam int VGA_H_SYNC   = 96;
   localparam int VGA_H_BP     = 48;
   localparam int VGA_V_ACTIVE = 480;
   localparam int VGA_V_FP     = 10;
   localparam int VGA_V_SYNC   = 2;
   localparam int VGA_V_BP     = 33;

   localparam int FB_IMG_W     = 160;
   localparam int FB_IMG_H     = 120;
   localparam int FB_ADDR_W    = 15;

   // Counter width covers the 800-cycle line and the 525-line frame.
   localparam int CNT_W        = 10;

   localparam int PIX_W        = 8;
   localparam int RGB_R_MSB    = 7;
   localparam int RGB_R_LSB    = 5;
   localparam int RGB_G_MSB    = 4;
   localparam int RGB_G_LSB    = 2;
   localparam int RGB_B_MSB    = 1;
   localparam int RGB_B_LSB    = 0;

   typedef struct packed {
      logic active;
      logic hsync_n;
      logic vsync_n;
      logic frame_start;
   } ctrl_t;

   localparam ctrl_t CTRL_IDLE = '{active: 1'b0, hsync_n: 1'b1, vsync_n: 1'b1, frame_start: 1'b0};

endpackage

// File: rtl/vga_timing_gen.sv
// Free-running horizontal/vertical counters with decoded sync, active and
// end-of-line/end-of-frame strobes, all valid in the same cycle as the counters.
module vga_timing_gen
   import vga_frame_reader_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP
) (
   input  logic             clk,
   input  logic             i_rst,
   output logic [CNT_W-1:0] o_h_cnt,
   output logic [CNT_W-1:0] o_v_cnt,
   output logic             o_active,
   output logic             o_hsync_n,
   output logic             o_vsync_n,
   output logic             o_line_end,
   output logic             o_frame_end
);

   localparam int H_TOTAL      = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL      = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int H_SYNC_START = H_ACTIVE + H_FP;
   localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
   localparam int V_SYNC_START = V_ACTIVE + V_FP;
   localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;

   logic [CNT_W-1:0] r_h_cnt;
   logic [CNT_W-1:0] r_v_cnt;
   logic             w_line_end;
   logic             w_frame_end;

   assign w_line_end  = (r_h_cnt == CNT_W'(H_TOTAL - 1));
   assign w_frame_end = w_line_end && (r_v_cnt == CNT_W'(V_TOTAL - 1));

   // NOTE: state registers use non-blocking assignments so every always_ff
   // samples the pre-edge value of every other register.
   always_ff @(posedge clk) begin
      if (i_rst) begin
         r_h_cnt <= '0;
         r_v_cnt <= '0;
      end else if (w_line_end) begin
         r_h_cnt <= '0;
         r_v_cnt <= w_frame_end ? '0 : r_v_cnt + CNT_W'(1);
      end else begin
         r_h_cnt <= r_h_cnt + CNT_W'(1);
      end
   end

   assign o_h_cnt     = r_h_cnt;
   assign o_v_cnt     = r_v_cnt;
   assign o_active    = (r_h_cnt < CNT_W'(H_ACTIVE)) && (r_v_cnt < CNT_W'(V_ACTIVE));
   assign o_hsync_n   = !((r_h_cnt >= CNT_W'(H_SYNC_START)) && (r_h_cnt < CNT_W'(H_SYNC_END)));
   assign o_vsync_n   = !((r_v_cnt >= CNT_W'(V_SYNC_START)) && (r_v_cnt < CNT_W'(V_SYNC_END)));
   assign o_line_end  = w_line_end;
   assign o_frame_end = w_frame_end;

endmodule

// File: rtl/vga_frame_reader.sv
// Reads the 4x-upscaled RGB332 frame buffer in raster order and drives VGA
// colour/sync through a 3-stage pipeline (counters, address, RAM, outputs).
module vga_frame_reader
   import vga_frame_reader_pkg::*;
#(
   parameter int H_ACTIVE = VGA_H_ACTIVE,
   parameter int H_FP     = VGA_H_FP,
   parameter int H_SYNC   = VGA_H_SYNC,
   parameter int H_BP     = VGA_H_BP,
   parameter int V_ACTIVE = VGA_V_ACTIVE,
   parameter int V_FP     = VGA_V_FP,
   parameter int V_SYNC   = VGA_V_SYNC,
   parameter int V_BP     = VGA_V_BP,
   parameter int IMG_W    = FB_IMG_W,
   parameter int IMG_H    = FB_IMG_H
) (
   input  logic                 clk,
   input  logic                 rst,
   output logic [FB_ADDR_W-1:0] DP_RAM_addr_out,
   input  logic [PIX_W-1:0]     DP_RAM_data_out,
   output logic                 VGA_Hsync_n,
   output logic                 VGA_Vsync_n,
   output logic [2:0]           VGA_R,
   output logic [2:0]           VGA_G,
   output logic [1:0]           VGA_B,
   output logic                 frame_start
);

   localparam logic [FB_ADDR_W-1:0] ROW_STEP      = FB_ADDR_W'(IMG_W);
   localparam logic [FB_ADDR_W-1:0] LAST_ROW_BASE = FB_ADDR_W'((IMG_H - 1) * IMG_W);

   logic [CNT_W-1:0]     w_h_cnt;
   logic [CNT_W-1:0]     w_v_cnt;
   logic                 w_active;
   logic                 w_hsync_n;
   logic                 w_vsync_n;
   logic                 w_line_end;
   logic                 w_frame_end;
   logic                 w_v_active;
   ctrl_t                w_ctrl_s0;
   logic [FB_ADDR_W-1:0] w_addr_next;

   logic [FB_ADDR_W-1:0] r_row_base;
   logic [FB_ADDR_W-1:0] r_addr;
   ctrl_t                r_ctrl_s1;
   ctrl_t                r_ctrl_s2;
   ctrl_t                r_ctrl_s3;
   logic [PIX_W-1:0]     r_pix;

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP)
   ) u_timing (
      .clk         (clk),
      .i_rst       (rst),
      .o_h_cnt     (w_h_cnt),
      .o_v_cnt     (w_v_cnt),
      .o_active    (w_active),
      .o_hsync_n   (w_hsync_n),
      .o_vsync_n   (w_vsync_n),
      .o_line_end  (w_line_end),
      .o_frame_end (w_frame_end)
   );

   assign w_v_active = (w_v_cnt < CNT_W'(V_ACTIVE));
   assign w_ctrl_s0  = '{active:      w_active,
                         hsync_n:     w_hsync_n,
                         vsync_n:     w_vsync_n,
                         frame_start: (w_h_cnt == '0) && (w_v_cnt == '0)};

   // Each stored row is shown on four lines; step to the next row after the fourth.
   always_ff @(posedge clk) begin
      if (rst || w_frame_end) begin
         r_row_base <= '0;
      end else if (w_line_end && w_v_active && (w_v_cnt[1:0] == 2'd3)) begin
         r_row_base <= (r_row_base == LAST_ROW_BASE) ? '0 : r_row_base + ROW_STEP;
      end
   end

   // NOTE: the default assignment first guarantees every path drives
   // w_addr_next, so no latch is inferred.
   always_comb begin
      w_addr_next = '0;
      if (w_active) begin
         if (w_h_cnt == '0)
            w_addr_next = r_row_base;
         else if (w_h_cnt[1:0] == 2'd0)
            w_addr_next = r_addr + FB_ADDR_W'(1);
         else
            w_addr_next = r_addr;
      end else if (w_v_active) begin
         w_addr_next = r_row_base;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr    <= '0;
         r_ctrl_s1 <= CTRL_IDLE;
         r_ctrl_s2 <= CTRL_IDLE;
         r_ctrl_s3 <= CTRL_IDLE;
         r_pix     <= '0;
      end else begin
         r_addr    <= w_addr_next;
         r_ctrl_s1 <= w_ctrl_s0;
         r_ctrl_s2 <= r_ctrl_s1;
         r_ctrl_s3 <= r_ctrl_s2;
         r_pix     <= r_ctrl_s2.active ? DP_RAM_data_out : '0;
      end
   end

   assign DP_RAM_addr_out = r_addr;
   assign VGA_Hsync_n     = r_ctrl_s3.hsync_n;
   assign VGA_Vsync_n     = r_ctrl_s3.vsync_n;
   assign frame_start     = r_ctrl_s3.frame_start;
   assign VGA_R           = r_pix[RGB_R_MSB:RGB_R_LSB];
   assign VGA_G           = r_pix[RGB_G_MSB:RGB_G_LSB];
   assign VGA_B           = r_pix[RGB_B_MSB:RGB_B_LSB];

endmodule

// File: tb/tb_vga_frame_reader.sv
// Scoreboard bench for vga_frame_reader on a reduced raster geometry so that
// whole frames, vertical blanking and mid-frame reset fit in a short run.
module tb_vga_frame_reader;

   localparam int HA = 64, HFP = 4, HS = 8, HBP = 4;
   localparam int VA = 48, VFP = 2, VS = 2, VBP = 3;
   localparam int IW = 16, IH = 12;
   localparam int HT = HA + HFP + HS + HBP;
   localparam int VT = VA + VFP + VS + VBP;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [14:0] addr;
   logic [7:0]  ram_q = 8'h00;
   logic        hs_n, vs_n, fs;
   logic [2:0]  vr, vg;
   logic [1:0]  vb;

   logic [7:0]  mem [0:32767];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;
   int mh       = 0;
   int mv       = 0;

   typedef struct {
      int          due;
      int          h;
      int          v;
      logic [31:0] addr;
   } addr_exp_t;

   typedef struct {
      int          due;
      int          h;
      int          v;
      logic [31:0] pix;
   } pix_exp_t;

   addr_exp_t addr_q[$];
   pix_exp_t  pix_q[$];

   vga_frame_reader #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP),
      .IMG_W(IW), .IMG_H(IH)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .DP_RAM_addr_out (addr),
      .DP_RAM_data_out (ram_q),
      .VGA_Hsync_n     (hs_n),
      .VGA_Vsync_n     (vs_n),
      .VGA_R           (vr),
      .VGA_G           (vg),
      .VGA_B           (vb),
      .frame_start     (fs)
   );

   always #5 clk = ~clk;

   // Synchronous-read RAM: data valid one cycle after the address.
   always @(posedge clk) ram_q <= mem[addr];
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input int h, input int v,
                        input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s at (h=%0d,v=%0d) cyc=%0d: got 0x%0h expected 0x%0h",
                  name, h, v, cyc, got, exp);
      end
   endtask

   // Reference: stored pixel (v/4, h/4); blank lines read row base, vblank reads 0.
   function automatic int ref_addr(input int h, input int v);
      if (v >= VA) return 0;
      if (h >= HA) return (v / 4) * IW;
      return (v / 4) * IW + h / 4;
   endfunction

   // Packs {hsync_n, vsync_n, frame_start, R, G, B} as seen on the outputs.
   function automatic logic [31:0] ref_pix(input int h, input int v);
      logic       act, hsn, vsn, fst;
      logic [7:0] col;
      act = (h < HA) && (v < VA);
      hsn = !((h >= HA + HFP) && (h < HA + HFP + HS));
      vsn = !((v >= VA + VFP) && (v < VA + VFP + VS));
      fst = (h == 0) && (v == 0);
      col = act ? mem[ref_addr(h, v)] : 8'h00;
      return {21'd0, hsn, vsn, fst, col};
   endfunction

   function automatic logic [31:0] idle_pix();
      return {21'd0, 1'b1, 1'b1, 1'b0, 8'h00};
   endfunction

   task automatic push_expect(input int h, input int v);
      addr_exp_t a;
      pix_exp_t  p;
      a = '{due: cyc + 1, h: h, v: v, addr: 32'(ref_addr(h, v))};
      p = '{due: cyc + 3, h: h, v: v, pix: ref_pix(h, v)};
      addr_q.push_back(a);
      pix_q.push_back(p);
   endtask

   // Monitor: compares whatever the scoreboard says is due this cycle.
   always @(negedge clk) begin
      addr_exp_t a;
      pix_exp_t  p;
      if (addr_q.size() != 0 && addr_q[0].due == cyc) begin
         a = addr_q.pop_front();
         check("addr", a.h, a.v, {17'd0, addr}, a.addr);
         if (a.h == HA - 1 && a.v == VA - 1)
            check("addr_last", a.h, a.v, {17'd0, addr}, IW * IH - 1);
      end
      if (pix_q.size() != 0 && pix_q[0].due == cyc) begin
         p = pix_q.pop_front();
         check("pix", p.h, p.v, {21'd0, hs_n, vs_n, fs, vr, vg, vb}, p.pix);
      end
   end

   // Called at a falling edge (or time 0); holds reset for n sampled edges.
   task automatic do_reset(input int n);
      pix_exp_t p;
      rst = 1'b1;
      #1;
      addr_q.delete();
      pix_q.delete();
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         check("rst_addr", -1, -1, {17'd0, addr}, 32'd0);
         check("rst_out", -1, -1, {21'd0, hs_n, vs_n, fs, vr, vg, vb}, idle_pix());
      end
      rst = 1'b0;
      mh  = 0;
      mv  = 0;
      p = '{due: cyc + 1, h: -1, v: -1, pix: idle_pix()};
      pix_q.push_back(p);
      p = '{due: cyc + 2, h: -1, v: -1, pix: idle_pix()};
      pix_q.push_back(p);
      push_expect(0, 0);
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         mh++;
         if (mh == HT) begin
            mh = 0;
            mv++;
            if (mv == VT) mv = 0;
         end
         push_expect(mh, mv);
      end
   endtask

   initial begin
      int rh, rv;

      // Phase 1: data = addr[7:0]; one full frame plus two lines.
      for (int i = 0; i < 32768; i++) mem[i] = 8'(i);
      do_reset(3);
      run(HT * VT + 2 * HT);

      // Phase 2: random image, full frame, then reset at a random raster point.
      for (int i = 0; i < 32768; i++) mem[i] = 8'($urandom);
      do_reset(2);
      run(HT * VT);
      rv = $urandom_range(1, VT - 1);
      rh = $urandom_range(0, HT - 1);
      run(rv * HT + rh);
      do_reset(5);
      run(HT * VT / 2);

      // Phase 3: all-ones RAM; blanking must force colour to zero.
      for (int i = 0; i < 32768; i++) mem[i] = 8'hFF;
      do_reset(2);
      run(HT * VT + 10);
      repeat (4) @(negedge clk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
